// File: rtl/mem_load_ctrl_if.sv
// Byte-stream input and parameter-memory write bus of mem_load_ctrl.
// slave = controller side, master = byte source / memory side.
interface mem_load_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/mem_load_ctrl.sv
// Parameter-memory load controller: streams DEPTH bytes into memory.
// Define MEM_LOAD_CHECKSUM_EN to add a trailing checksum byte and checksum_ok.
module mem_load_ctrl #(
  parameter int DEPTH  = 162,
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  mem_load_ctrl_if.slave  bus,
  output logic            busy,
  output logic            done,
  output logic [ADDR_W:0] count
`ifdef MEM_LOAD_CHECKSUM_EN
  ,
  output logic            checksum_ok
`endif
);

`ifdef MEM_LOAD_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE, LOAD, CHECK, DONE
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, LOAD, DONE
  } state_t;
`endif

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [7:0]        mdata_q, mdata_d;
  logic              we_q, we_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              xfer;
`ifdef MEM_LOAD_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              chk_q, chk_d;
`endif

  // byte_ready is the registered busy flag
  assign xfer = busy_q & bus.byte_valid;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    we_d    = 1'b0;
    done_d  = done_q;
`ifdef MEM_LOAD_CHECKSUM_EN
    sum_d   = sum_q;
    chk_d   = chk_q;
`endif
    if (busy_q && abort) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end else if (start) begin
      state_d = LOAD;
      addr_d  = '0;
      count_d = '0;
      done_d  = 1'b0;
`ifdef MEM_LOAD_CHECKSUM_EN
      sum_d   = '0;
      chk_d   = 1'b0;
`endif
    end else if (xfer && state_q == LOAD) begin
      we_d    = 1'b1;
      maddr_d = addr_q;
      mdata_d = bus.byte_in;
      addr_d  = addr_q + ADDR_W'(1);
      count_d = count_q + (ADDR_W+1)'(1);
`ifdef MEM_LOAD_CHECKSUM_EN
      sum_d   = sum_q + bus.byte_in;
      if (addr_q == LAST) begin
        state_d = CHECK;
      end
`else
      if (addr_q == LAST) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
`endif
`ifdef MEM_LOAD_CHECKSUM_EN
    end else if (xfer && state_q == CHECK) begin
      chk_d   = (bus.byte_in == sum_q);
      state_d = DONE;
      done_d  = 1'b1;
`endif
    end
`ifdef MEM_LOAD_CHECKSUM_EN
    busy_d = (state_d == LOAD) ||
             (state_d == CHECK);
`else
    busy_d = (state_d == LOAD);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MEM_LOAD_CHECKSUM_EN
      sum_q   <= '0;
      chk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef MEM_LOAD_CHECKSUM_EN
      sum_q   <= sum_d;
      chk_q   <= chk_d;
`endif
    end
  end

  assign bus.byte_ready = busy_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_data   = mdata_q;
  assign bus.mem_we     = we_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign count          = count_q;
`ifdef MEM_LOAD_CHECKSUM_EN
  assign checksum_ok    = chk_q;
`endif

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Randomized bench for mem_load_ctrl against a transaction-level model.
// Define MEM_LOAD_CHECKSUM_EN to also exercise the checksum byte.
module tb_mem_load_ctrl;
  localparam int DEPTH = 162;
  localparam int AW    = 8;
`ifdef MEM_LOAD_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done;
  logic [AW:0] count;
`ifdef MEM_LOAD_CHECKSUM_EN
  logic checksum_ok;
`endif
  int vectors = 0;
  int miscompares = 0;

  mem_load_ctrl_if #(.ADDR_W(AW)) bus ();

  mem_load_ctrl #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .bus(bus),
    .busy(busy),
    .done(done),
    .count(count)
`ifdef MEM_LOAD_CHECKSUM_EN
    ,
    .checksum_ok(checksum_ok)
`endif
  );

  always #5 clk = ~clk;

  // model: session flag, next address, accepted count, pending write
  bit       m_active, m_done, m_ok, e_we;
  int       m_addr, m_cnt;
  logic [7:0] m_sum, e_addr, e_data;

  task automatic mreset();
    m_active = 0; m_done = 0; m_ok = 0; e_we = 0;
    m_addr = 0; m_cnt = 0; m_sum = 0;
  endtask

  task automatic step(input bit s, input bit a,
                      input bit v, input logic [7:0] b);
    bit x;
    start = s; abort = a;
    bus.byte_valid = v; bus.byte_in = b;
    @(posedge clk);
    x = m_active && v && !s && !a;
    e_we = x && (m_addr < DEPTH);
    if (e_we) begin
      e_addr = 8'(m_addr); e_data = b;
    end
    if (m_active && a) begin
      m_active = 0; m_done = 0;
    end else if (s) begin
      m_active = 1; m_done = 0; m_ok = 0;
      m_addr = 0; m_cnt = 0; m_sum = 0;
    end else if (x && m_addr < DEPTH) begin
      m_addr++; m_cnt++; m_sum = m_sum + b;
      if (m_addr == DEPTH && !CHK) begin
        m_active = 0; m_done = 1;
      end
    end else if (x) begin
      m_ok = (b == m_sum);
      m_active = 0; m_done = 1;
    end
    #1;
    start = 0; abort = 0; bus.byte_valid = 0;
  endtask

  function automatic logic [28:0] obs();
    return {bus.mem_we,
            bus.mem_we ? bus.mem_addr : 8'h0,
            bus.mem_we ? bus.mem_data : 8'h0,
            busy, bus.byte_ready, done, count};
  endfunction

  function automatic logic [28:0] expv();
    return {e_we, e_we ? e_addr : 8'h0,
            e_we ? e_data : 8'h0,
            m_active, m_active, m_done, 9'(m_cnt)};
  endfunction

  task automatic test_reset();
    reset = 1; bus.byte_valid = 0; bus.byte_in = 0;
    repeat (2) @(posedge clk);
    #1; mreset();
    vectors++;
    if ({obs(), bus.mem_addr, bus.mem_data} !== 45'h0) begin
      miscompares++;
      $display("FAIL reset_state got %h want 0",
               {obs(), bus.mem_addr, bus.mem_data});
    end
    #4 reset = 0;
    step(1, 0, 0, 8'h0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 8'($urandom));
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL pre_reset i=%0d got %h want %h",
                 i, obs(), expv());
      end
    end
    reset = 1; bus.byte_valid = 1; bus.byte_in = 8'h5a;
    #1; mreset();
    vectors++;
    if ({obs(), bus.mem_addr, bus.mem_data} !== 45'h0) begin
      miscompares++;
      $display("FAIL async_reset got %h want 0",
               {obs(), bus.mem_addr, bus.mem_data});
    end
    #3 reset = 0;
    step(0, 0, 1, 8'h33);
    vectors++;
    if (obs() !== expv()) begin
      miscompares++;
      $display("FAIL post_reset got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_full_load();
    step(1, 0, 0, 8'h0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 8'(i));
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL full_load i=%0d got %h want %h",
                 i, obs(), expv());
      end
    end
    if (CHK) step(0, 0, 1, m_sum);
    step(0, 0, 0, 8'h0);
    vectors++;
    if ({done, busy, count} !== {1'b1, 1'b0, 9'(DEPTH)}) begin
      miscompares++;
      $display("FAIL full_done got %b/%b/%0d want 1/0/%0d",
               done, busy, count, DEPTH);
    end
  endtask

  task automatic test_toggle();
    int cyc = 0;
    step(1, 0, 0, 8'h0);
    while (m_active && cyc < 1000) begin
      step(0, 0, cyc[0], 8'($urandom));
      cyc++;
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL toggle cyc=%0d got %h want %h",
                 cyc, obs(), expv());
      end
    end
    vectors++;
    if (m_active) begin
      miscompares++;
      $display("FAIL toggle_timeout got busy=%b want 0", busy);
    end
  endtask

  task automatic test_idle_bytes();
    for (int i = 0; i < 20; i++) begin
      step(0, i == 5, 1, 8'($urandom));
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL idle_bytes i=%0d got %h want %h",
                 i, obs(), expv());
      end
    end
  endtask

  task automatic test_abort();
    step(1, 0, 0, 8'h0);
    for (int i = 0; i < 50; i++) step(0, 0, 1, 8'($urandom));
    step(1, 1, 1, 8'hee);
    vectors++;
    if (obs() !== expv() || count !== 9'd50) begin
      miscompares++;
      $display("FAIL abort got %h want %h", obs(), expv());
    end
    step(1, 0, 0, 8'h0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 8'($urandom));
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL abort_reload i=%0d got %h want %h",
                 i, obs(), expv());
      end
    end
  endtask

  task automatic test_restart();
    int cyc = 0;
    step(1, 0, 0, 8'h0);
    for (int i = 0; i < 80; i++) step(0, 0, 1, 8'($urandom));
    step(1, 0, 1, 8'haa);
    vectors++;
    if (obs() !== expv()) begin
      miscompares++;
      $display("FAIL restart_nowrite got %h want %h",
               obs(), expv());
    end
    step(0, 0, 1, 8'h5c);
    vectors++;
    if (obs() !== expv()) begin
      miscompares++;
      $display("FAIL restart_addr0 got %h want %h",
               obs(), expv());
    end
    while (m_active && cyc < 1000) begin
      step(0, 0, 1'($urandom), 8'($urandom));
      cyc++;
    end
    vectors++;
    if (obs() !== expv() || m_active) begin
      miscompares++;
      $display("FAIL restart_finish got %h want %h",
               obs(), expv());
    end
  endtask

  task automatic test_random();
    bit s, a;
    for (int i = 0; i < 4000; i++) begin
      s = m_active ? ($urandom_range(0, 199) == 0)
                   : ($urandom_range(0, 9) == 0);
      a = m_active ? ($urandom_range(0, 299) == 0)
                   : ($urandom_range(0, 19) == 0);
      step(s, a, 1'($urandom), 8'($urandom));
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL random i=%0d got %h want %h",
                 i, obs(), expv());
      end
    end
  endtask

`ifdef MEM_LOAD_CHECKSUM_EN
  task automatic test_checksum(input logic [7:0] tail);
    step(1, 0, 0, 8'h0);
    for (int i = 0; i <= DEPTH; i++) begin
      step(0, 0, 1, (i == DEPTH) ? tail : 8'h01);
      vectors++;
      if (obs() !== expv()) begin
        miscompares++;
        $display("FAIL checksum i=%0d got %h want %h",
                 i, obs(), expv());
      end
    end
    vectors++;
    if (checksum_ok !== m_ok) begin
      miscompares++;
      $display("FAIL checksum_ok tail=%h got %b want %b",
               tail, checksum_ok, m_ok);
    end
  endtask
`endif

  initial begin
    bus.byte_in = 8'h0;
    bus.byte_valid = 1'b0;
    mreset();
    test_reset();
    test_idle_bytes();
    test_full_load();
    test_idle_bytes();
    test_toggle();
    test_abort();
    test_restart();
`ifdef MEM_LOAD_CHECKSUM_EN
    test_checksum(8'hA2);
    test_checksum(8'h00);
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_load_ctrl.md
MEM_LOAD_CTRL -- requirements
Module: mem_load_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 162, number of 8-bit parameter-memory words loaded per session.
REQ-002 SHALL have parameter ADDR_W, default 8, address width, with 2^ADDR_W >= DEPTH.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load session at address 0.
REQ-006 SHALL have port abort  input  1  terminates an active session without completion.
REQ-007 SHALL have port byte_in  input  8  incoming parameter byte.
REQ-008 SHALL have port byte_valid  input  1  byte_in is valid this cycle.
REQ-009 SHALL have port byte_ready  output  1  controller accepts a byte this cycle.
REQ-010 SHALL have port mem_addr  output  ADDR_W  write address to parameter memory.
REQ-011 SHALL have port mem_data  output  8  write data to parameter memory.
REQ-012 SHALL have port mem_we  output  1  write enable to parameter memory.
REQ-013 SHALL have port busy  output  1  session in progress.
REQ-014 SHALL have port done  output  1  last session completed normally; held until the next start or reset.
REQ-015 SHALL have port count  output  ADDR_W+1  bytes accepted in the current or last session.

Function
REQ-016 SHALL implement states IDLE, LOAD, DONE (plus CHECK when MEM_LOAD_CHECKSUM_EN is defined).
REQ-017 SHALL move IDLE->LOAD or DONE->LOAD on start=1, clear count and the address counter to 0, and clear done.
REQ-018 SHALL drive byte_ready=1 only in LOAD (and CHECK); a transfer occurs when byte_valid and byte_ready are both 1 on a rising edge.
REQ-019 SHALL, on each LOAD transfer, register mem_addr=address counter and mem_data=byte_in, and assert mem_we=1 for exactly the following cycle (1-cycle latency, one write per transfer).
REQ-020 SHALL keep mem_we=0 in every cycle not immediately following a LOAD transfer.
REQ-021 SHALL increment the address counter and count by 1 per transfer, with no wrap-around.
REQ-022 SHALL, on the transfer at address DEPTH-1, leave LOAD for DONE (or for CHECK when the checksum is enabled); no address >= DEPTH is ever written.
REQ-023 SHALL hold byte_ready=0 in IDLE and DONE; byte_valid in those states is ignored and no write occurs.
REQ-024 SHALL restart a session when start=1 in LOAD (restart has priority over a simultaneous transfer): next state LOAD, address 0, count 0, and no write for that cycle's byte.
REQ-025 SHALL go to IDLE with done=0 when abort=1 in LOAD or CHECK; abort has priority over start and transfers, and words already written are left in memory.
REQ-026 SHALL drive busy=1 exactly in LOAD and CHECK.

Reset
REQ-027 SHALL, while reset=1, force state IDLE, address counter 0, count 0, mem_addr 0, mem_data 0, mem_we 0, done 0, busy 0 and byte_ready 0, independent of clk.
REQ-028 SHALL issue no memory write in the first cycle after reset deasserts, even if a transfer was accepted in the cycle reset asserted.

Configuration
REQ-029 SHALL, when macro MEM_LOAD_CHECKSUM_EN is defined, add output checksum_ok (1 bit, reset 0) and an 8-bit running sum (mod 256) of the accepted data bytes.
REQ-030 SHALL, with MEM_LOAD_CHECKSUM_EN defined, accept one extra byte in CHECK without writing it, set checksum_ok=(byte==sum), and go to DONE; checksum_ok is cleared on start.
REQ-031 SHALL, without MEM_LOAD_CHECKSUM_EN, have no CHECK state and no checksum_ok port, and go from LOAD to DONE directly.

Verification
REQ-032 Reset, then start, then 162 back-to-back valid bytes i -> writes to addresses 0..161 with data i, one cycle after each transfer; done=1; count=162; busy=0.
REQ-033 byte_valid toggled every other cycle during a session -> exactly one mem_we pulse per accepted byte; addresses stay contiguous.
REQ-034 Bytes presented in IDLE and after DONE -> byte_ready=0 and mem_we never asserts.
REQ-035 abort after 50 bytes -> state IDLE, done=0, count=50; a later start reloads from address 0.
REQ-036 start asserted together with byte_valid at address 80 -> no write in the next cycle; the next accepted byte is written to address 0.
REQ-037 With MEM_LOAD_CHECKSUM_EN defined: 162 bytes of 0x01 followed by 0xA2 -> checksum_ok=1; the same bytes followed by 0x00 -> checksum_ok=0; in both cases address 162 is never written.
